// File: rtl/arbiter_grant_hold.sv
// rtl/arbiter_grant_hold.sv - registered grant-hold stage around a combinational daisy-chain arbiter
// Latches the arbiter's grant, holds it until release or timeout, and masks timed-out requesters.
module arbiter_grant_hold #(
  parameter  int N        = 8,
  parameter  int HOLD_MAX = 16,
  localparam int IDXW     = (N > 1) ? $clog2(N) : 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [0:N-1]    req,
  input  logic            done,
  output logic [0:N-1]    req_arb,
  input  logic [0:N-1]    arb_gnt,
  output logic [0:N-1]    gnt,
  output logic            gnt_valid,
  output logic [IDXW-1:0] gnt_idx,
  output logic            timeout,
  output logic            err
);

  localparam int CNTW = (HOLD_MAX > 0) ? $clog2(HOLD_MAX + 1) : 1;
  localparam logic [CNTW-1:0] CNT_LAST = CNTW'((HOLD_MAX > 0) ? HOLD_MAX - 1 : 0);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] GAP  = 2'd2;

  logic [1:0]      state_q, state_d;
  logic [0:N-1]    gnt_q, gnt_d;
  logic            gnt_valid_q, gnt_valid_d;
  logic [IDXW-1:0] gnt_idx_q, gnt_idx_d;
  logic            timeout_q, timeout_d;
  logic            err_q, err_d;
  logic [CNTW-1:0] cnt_q, cnt_d;
  logic [0:N-1]    penalty_q, penalty_d;

  logic [0:N-1]    pick_onehot;
  logic [IDXW-1:0] pick_idx;
  logic            pick_found;
  logic            pick_multi;
  logic [0:N-1]    pen_set;

  assign req_arb = req & ~penalty_q;

  // Lowest index wins; any further set bit flags a malformed arbiter grant.
  always_comb begin
    pick_onehot = '0;
    pick_idx    = '0;
    pick_found  = 1'b0;
    pick_multi  = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (arb_gnt[i]) begin
        if (!pick_found) begin
          pick_onehot[i] = 1'b1;
          pick_idx       = IDXW'(i);
          pick_found     = 1'b1;
        end else begin
          pick_multi = 1'b1;
        end
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    gnt_d       = gnt_q;
    gnt_valid_d = gnt_valid_q;
    gnt_idx_d   = gnt_idx_q;
    cnt_d       = cnt_q;
    timeout_d   = 1'b0;
    err_d       = 1'b0;
    pen_set     = '0;
    case (state_q)
      IDLE: begin
        if (pick_found) begin
          gnt_d       = pick_onehot;
          gnt_idx_d   = pick_idx;
          gnt_valid_d = 1'b1;
          cnt_d       = '0;
          err_d       = pick_multi;
          state_d     = BUSY;
        end
      end
      BUSY: begin
        if (done || !(|(req & gnt_q))) begin
          gnt_d       = '0;
          gnt_valid_d = 1'b0;
          gnt_idx_d   = '0;
          state_d     = GAP;
        end else if (HOLD_MAX != 0 && cnt_q == CNT_LAST) begin
          gnt_d       = '0;
          gnt_valid_d = 1'b0;
          gnt_idx_d   = '0;
          timeout_d   = 1'b1;
          pen_set     = gnt_q;
          state_d     = GAP;
        end else if (HOLD_MAX != 0) begin
          cnt_d = cnt_q + CNTW'(1);
        end
      end
      GAP: begin
        state_d = IDLE;
      end
      default: begin
        state_d     = IDLE;
        gnt_d       = '0;
        gnt_valid_d = 1'b0;
        gnt_idx_d   = '0;
      end
    endcase
    // A dropped request clears its penalty even if it was set this same cycle.
    penalty_d = (penalty_q | pen_set) & req;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      gnt_q       <= '0;
      gnt_valid_q <= 1'b0;
      gnt_idx_q   <= '0;
      timeout_q   <= 1'b0;
      err_q       <= 1'b0;
      cnt_q       <= '0;
      penalty_q   <= '0;
    end else begin
      state_q     <= state_d;
      gnt_q       <= gnt_d;
      gnt_valid_q <= gnt_valid_d;
      gnt_idx_q   <= gnt_idx_d;
      timeout_q   <= timeout_d;
      err_q       <= err_d;
      cnt_q       <= cnt_d;
      penalty_q   <= penalty_d;
    end
  end

  assign gnt       = gnt_q;
  assign gnt_valid = gnt_valid_q;
  assign gnt_idx   = gnt_idx_q;
  assign timeout   = timeout_q;
  assign err       = err_q;

endmodule

// File: tb/tb_arbiter_grant_hold.sv
// tb/tb_arbiter_grant_hold.sv - self-checking bench for arbiter_grant_hold
// Cycle vectors: inputs for one cycle, req_arb during it, registered outputs after its edge.
module tb_arbiter_grant_hold;

  logic       clk = 1'b0;
  logic       reset;
  logic [0:7] req;
  logic       done;
  logic [0:7] req_arb;
  logic [0:7] arb_gnt;
  logic [0:7] gnt;
  logic       gnt_valid;
  logic [2:0] gnt_idx;
  logic       timeout;
  logic       err;

  arbiter_grant_hold #(.N(8), .HOLD_MAX(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .req       (req),
    .done      (done),
    .req_arb   (req_arb),
    .arb_gnt   (arb_gnt),
    .gnt       (gnt),
    .gnt_valid (gnt_valid),
    .gnt_idx   (gnt_idx),
    .timeout   (timeout),
    .err       (err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic [7:0] rq;
    logic       dn;
    logic [7:0] ag;
    logic [7:0] e_ra;
    logic [7:0] e_gnt;
    logic       e_valid;
    logic [2:0] e_idx;
    logic       e_to;
    logic       e_err;
  } vec_t;

  vec_t tbl[$];
  vec_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   step_no = 0;

  function automatic vec_t mk(input logic rst, input logic [7:0] rq, input logic dn,
                              input logic [7:0] ag, input logic [7:0] e_ra,
                              input logic [7:0] e_gnt, input logic e_valid,
                              input logic [2:0] e_idx, input logic e_to, input logic e_err);
    vec_t v;
    v.rst = rst; v.rq = rq; v.dn = dn; v.ag = ag; v.e_ra = e_ra;
    v.e_gnt = e_gnt; v.e_valid = e_valid; v.e_idx = e_idx; v.e_to = e_to; v.e_err = e_err;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL step%0d %s: got %0h expected %0h", step_no, nm, act, exp);
    end
  endtask

  task automatic step(input vec_t v);
    vec_t e;
    @(negedge clk);
    reset   = v.rst;
    req     = v.rq;
    done    = v.dn;
    arb_gnt = v.ag;
    sb.push_back(v);
    #1;
    chk("req_arb", {24'd0, req_arb}, {24'd0, v.e_ra});
    @(posedge clk);
    #1;
    e = sb.pop_front();
    chk("gnt",       {24'd0, gnt},       {24'd0, e.e_gnt});
    chk("gnt_valid", {31'd0, gnt_valid}, {31'd0, e.e_valid});
    chk("gnt_idx",   {29'd0, gnt_idx},   {29'd0, e.e_idx});
    chk("timeout",   {31'd0, timeout},   {31'd0, e.e_to});
    chk("err",       {31'd0, err},       {31'd0, e.e_err});
    step_no++;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; req = 8'h00; done = 1'b0; arb_gnt = 8'h00;
    @(posedge clk);
    #1;

    // reset with all requests raised
    tbl.push_back(mk(1, 8'hFF, 0, 8'h00, 8'hFF, 8'h00, 0, 0, 0, 0));
    tbl.push_back(mk(1, 8'hFF, 0, 8'h00, 8'hFF, 8'h00, 0, 0, 0, 0));
    // grant idx2, release by dropped request, GAP ignores arb_gnt
    tbl.push_back(mk(0, 8'h20, 0, 8'h20, 8'h20, 8'h20, 1, 2, 0, 0));
    tbl.push_back(mk(0, 8'h00, 0, 8'h00, 8'h00, 8'h00, 0, 0, 0, 0));
    tbl.push_back(mk(0, 8'h80, 0, 8'h80, 8'h80, 8'h00, 0, 0, 0, 0));
    tbl.push_back(mk(0, 8'h80, 0, 8'h80, 8'h80, 8'h80, 1, 0, 0, 0));
    tbl.push_back(mk(0, 8'h80, 1, 8'h00, 8'h80, 8'h00, 0, 0, 0, 0));
    tbl.push_back(mk(0, 8'h00, 0, 8'h00, 8'h00, 8'h00, 0, 0, 0, 0));
    // idx2 held while idx0 requests; done releases, then idx0 wins after GAP
    tbl.push_back(mk(0, 8'h20, 0, 8'h20, 8'h20, 8'h20, 1, 2, 0, 0));
    tbl.push_back(mk(0, 8'hA0, 0, 8'h80, 8'hA0, 8'h20, 1, 2, 0, 0));
    tbl.push_back(mk(0, 8'hA0, 1, 8'h80, 8'hA0, 8'h00, 0, 0, 0, 0));
    tbl.push_back(mk(0, 8'hA0, 0, 8'h80, 8'hA0, 8'h00, 0, 0, 0, 0));
    tbl.push_back(mk(0, 8'hA0, 0, 8'h80, 8'hA0, 8'h80, 1, 0, 0, 0));
    tbl.push_back(mk(0, 8'h00, 0, 8'h00, 8'h00, 8'h00, 0, 0, 0, 0));
    tbl.push_back(mk(0, 8'h00, 0, 8'h00, 8'h00, 8'h00, 0, 0, 0, 0));
    // multi-hot arbiter grant: lowest index wins, err for one cycle
    tbl.push_back(mk(0, 8'h50, 0, 8'h50, 8'h50, 8'h40, 1, 1, 0, 1));
    tbl.push_back(mk(0, 8'h50, 0, 8'h00, 8'h50, 8'h40, 1, 1, 0, 0));
    tbl.push_back(mk(0, 8'h00, 0, 8'h00, 8'h00, 8'h00, 0, 0, 0, 0));
    tbl.push_back(mk(0, 8'h00, 0, 8'h00, 8'h00, 8'h00, 0, 0, 0, 0));
    // highest index
    tbl.push_back(mk(0, 8'h01, 0, 8'h01, 8'h01, 8'h01, 1, 7, 0, 0));
    tbl.push_back(mk(0, 8'h00, 0, 8'h00, 8'h00, 8'h00, 0, 0, 0, 0));
    tbl.push_back(mk(0, 8'h00, 0, 8'h00, 8'h00, 8'h00, 0, 0, 0, 0));

    for (int i = 0; i < tbl.size(); i++) step(tbl[i]);

    // idx3 held forever: four valid cycles, timeout pulse, penalty until req drops
    step(mk(0, 8'h10, 0, 8'h10, 8'h10, 8'h10, 1, 3, 0, 0));
    for (int i = 0; i < 3; i++) step(mk(0, 8'h10, 0, 8'h00, 8'h10, 8'h10, 1, 3, 0, 0));
    step(mk(0, 8'h10, 0, 8'h00, 8'h10, 8'h00, 0, 0, 1, 0));
    step(mk(0, 8'h10, 0, 8'h10, 8'h00, 8'h00, 0, 0, 0, 0));
    step(mk(0, 8'h10, 0, 8'h00, 8'h00, 8'h00, 0, 0, 0, 0));
    step(mk(0, 8'h00, 0, 8'h00, 8'h00, 8'h00, 0, 0, 0, 0));
    step(mk(0, 8'h10, 0, 8'h00, 8'h10, 8'h00, 0, 0, 0, 0));

    // done in the timeout cycle: normal release, no pulse, no penalty
    step(mk(0, 8'h10, 0, 8'h10, 8'h10, 8'h10, 1, 3, 0, 0));
    for (int i = 0; i < 3; i++) step(mk(0, 8'h10, 0, 8'h00, 8'h10, 8'h10, 1, 3, 0, 0));
    step(mk(0, 8'h10, 1, 8'h00, 8'h10, 8'h00, 0, 0, 0, 0));
    step(mk(0, 8'h10, 0, 8'h00, 8'h10, 8'h00, 0, 0, 0, 0));
    step(mk(0, 8'h00, 0, 8'h00, 8'h00, 8'h00, 0, 0, 0, 0));

    // reset mid-BUSY with penalty on idx3 clears everything
    step(mk(0, 8'h10, 0, 8'h10, 8'h10, 8'h10, 1, 3, 0, 0));
    for (int i = 0; i < 3; i++) step(mk(0, 8'h10, 0, 8'h00, 8'h10, 8'h10, 1, 3, 0, 0));
    step(mk(0, 8'h10, 0, 8'h00, 8'h10, 8'h00, 0, 0, 1, 0));
    step(mk(0, 8'h14, 0, 8'h00, 8'h04, 8'h00, 0, 0, 0, 0));
    step(mk(0, 8'h14, 0, 8'h04, 8'h04, 8'h04, 1, 5, 0, 0));
    step(mk(1, 8'h14, 0, 8'h04, 8'h04, 8'h00, 0, 0, 0, 0));
    step(mk(0, 8'h14, 0, 8'h00, 8'h14, 8'h00, 0, 0, 0, 0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
